// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache: load/store
// width encodings, controller states and address-split geometry.
package dcache_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int unsigned OFFSET_W    = 4;
   localparam int unsigned DEF_LINES   = 8;
   localparam int unsigned DEF_INDEX_W = 3;
   localparam int unsigned DEF_TAG_W   = 32 - OFFSET_W - DEF_INDEX_W;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_ALLOCATE  = 2'd2
   } state_e;

endpackage

// File: rtl/dcache_align.sv
// Byte-lane steering between a 16-byte line and the 32-bit CPU port:
// load select with sign/zero extension, store byte enables with replicated data.
module dcache_align
   import dcache_pkg::*;
(
   input  logic [2:0]   funct3_i,
   input  logic [3:0]   offset_i,
   input  logic [127:0] line_i,
   input  logic [31:0]  wdata_i,
   output logic [31:0]  rdata_o,
   output logic [15:0]  byte_en_o,
   output logic [127:0] wline_o
);

   logic [3:0]  offset_al;
   logic [3:0]  lane;
   logic [15:0] size_mask;
   logic [31:0] word;
   logic        st_ok;

   always_comb begin
      offset_al = offset_i;
      size_mask = 16'h0001;
      wline_o   = {16{wdata_i[7:0]}};
      case (funct3_i[1:0])
         2'b01: begin
            offset_al = {offset_i[3:1], 1'b0};
            size_mask = 16'h0003;
            wline_o   = {8{wdata_i[15:0]}};
         end
         2'b10: begin
            offset_al = {offset_i[3:2], 2'b00};
            size_mask = 16'h000F;
            wline_o   = {4{wdata_i}};
         end
         default: ;
      endcase

      // Lanes past the top of the line wrap; they are only read by widths
      // whose aligned offset keeps them inside the line.
      word = '0;
      lane = '0;
      for (int k = 0; k < 4; k++) begin
         lane = offset_al + 4'(k);
         word[8*k +: 8] = line_i[{lane, 3'b000} +: 8];
      end

      case (funct3_i)
         F3_B:    rdata_o = {{24{word[7]}}, word[7:0]};
         F3_H:    rdata_o = {{16{word[15]}}, word[15:0]};
         F3_W:    rdata_o = word;
         F3_BU:   rdata_o = {24'b0, word[7:0]};
         F3_HU:   rdata_o = {16'b0, word[15:0]};
         default: rdata_o = '0;
      endcase

      st_ok     = (funct3_i == F3_B) || (funct3_i == F3_H) || (funct3_i == F3_W);
      byte_en_o = st_ok ? (size_mask << offset_al) : 16'h0000;
   end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage
// and 128-bit block memory. Stalls the pipeline with BUSYWAIT on a miss.
//
//   state        | meaning
//   ST_IDLE      | serve hits; on a miss pick write-back or refill
//   ST_WRITEBACK | push dirty victim block to memory
//   ST_ALLOCATE  | fetch requested block, install clean, then back to idle
module data_cache
   import dcache_pkg::*;
#(
   parameter int unsigned NUM_LINES   = DEF_LINES,
   parameter int unsigned BLOCK_BYTES = 16
) (
   input  logic         CLOCK,
   input  logic         RESET,
   input  logic         READ,
   input  logic         WRITE,
   input  logic [2:0]   FUNCT3,
   input  logic [31:0]  ADDRESS,
   input  logic [31:0]  WRITEDATA,
   output logic [31:0]  READDATA,
   output logic         BUSYWAIT,
   output logic         MEM_READ,
   output logic         MEM_WRITE,
   output logic [27:0]  MEM_ADDRESS,
   output logic [127:0] MEM_WRITEDATA,
   input  logic [127:0] MEM_READDATA,
   input  logic         MEM_BUSYWAIT
);

   localparam int unsigned IDX_W   = $clog2(NUM_LINES);
   localparam int unsigned TAG_W   = 32 - OFFSET_W - IDX_W;
   localparam int unsigned BLOCK_W = BLOCK_BYTES * 8;

   state_e state_q, state_d;

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [BLOCK_W-1:0]   data_q [NUM_LINES];

   logic [IDX_W-1:0]   index;
   logic [TAG_W-1:0]   tag;
   logic               hit;
   logic               access;
   logic               load_hit;
   logic               store_hit;
   logic               refill_en;
   logic [31:0]        ld_data;
   logic [15:0]        byte_en;
   logic [BLOCK_W-1:0] wline;
   logic [BLOCK_W-1:0] wmask;

   assign index     = ADDRESS[OFFSET_W +: IDX_W];
   assign tag       = ADDRESS[31 -: TAG_W];
   assign hit       = valid_q[index] && (tag_q[index] == tag);
   assign access    = READ ^ WRITE;
   assign load_hit  = READ && !WRITE && hit;
   assign store_hit = WRITE && !READ && hit && (state_q == ST_IDLE);

   dcache_align u_align (
      .funct3_i  (FUNCT3),
      .offset_i  (ADDRESS[3:0]),
      .line_i    (data_q[index]),
      .wdata_i   (WRITEDATA),
      .rdata_o   (ld_data),
      .byte_en_o (byte_en),
      .wline_o   (wline)
   );

   assign READDATA = load_hit ? ld_data : 32'h0;

   always_comb begin
      wmask = '0;
      for (int k = 0; k < 16; k++) begin
         wmask[8*k +: 8] = {8{byte_en[k]}};
      end
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      BUSYWAIT      = 1'b0;
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = '0;
      MEM_WRITEDATA = '0;
      refill_en     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (access && !hit) begin
               BUSYWAIT = 1'b1;
               state_d  = (valid_q[index] && dirty_q[index]) ? ST_WRITEBACK : ST_ALLOCATE;
            end
         end
         ST_WRITEBACK: begin
            BUSYWAIT      = 1'b1;
            MEM_WRITE     = 1'b1;
            MEM_ADDRESS   = {tag_q[index], index};
            MEM_WRITEDATA = data_q[index];
            if (!MEM_BUSYWAIT) state_d = ST_ALLOCATE;
         end
         ST_ALLOCATE: begin
            BUSYWAIT    = 1'b1;
            MEM_READ    = 1'b1;
            MEM_ADDRESS = ADDRESS[31:OFFSET_W];
            if (!MEM_BUSYWAIT) begin
               refill_en = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A request held across reset must not stall the pipeline.
      if (!RESET) BUSYWAIT = 1'b0;
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (refill_en) begin
         valid_q[index] <= 1'b1;
         dirty_q[index] <= 1'b0;
      end else if (store_hit) begin
         dirty_q[index] <= 1'b1;
      end
   end

   // Tag and data arrays need no reset: valid_q gates every use.
   always_ff @(posedge CLOCK) begin
      if (refill_en) begin
         tag_q[index]  <= tag;
         data_q[index] <= MEM_READDATA;
      end else if (store_hit) begin
         data_q[index] <= (data_q[index] & ~wmask) | (wline & wmask);
      end
   end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed vector table, hand sequences
// for reset and dual-request cases, and random traffic against a flat-memory model.
module tb_data_cache;
   import dcache_pkg::*;

   logic         CLOCK     = 1'b0;
   logic         RESET     = 1'b1;
   logic         READ      = 1'b0;
   logic         WRITE     = 1'b0;
   logic [2:0]   FUNCT3    = 3'b010;
   logic [31:0]  ADDRESS   = 32'h0;
   logic [31:0]  WRITEDATA = 32'h0;
   logic [31:0]  READDATA;
   logic         BUSYWAIT;
   logic         MEM_READ;
   logic         MEM_WRITE;
   logic [27:0]  MEM_ADDRESS;
   logic [127:0] MEM_WRITEDATA;
   logic [127:0] MEM_READDATA = '0;
   logic         MEM_BUSYWAIT = 1'b0;

   data_cache #(.NUM_LINES(8), .BLOCK_BYTES(16)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .FUNCT3(FUNCT3),
      .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
      .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
      .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
   );

   always #5 CLOCK = ~CLOCK;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_w(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Block memory: unwritten blocks hold byte value = low 8 bits of byte address.
   logic [127:0] mem [logic [27:0]];
   int           mem_lat = 0;
   int           req_cnt = 0;
   int           n_wb = 0, n_rf = 0, n_excl = 0;
   logic [27:0]  last_wb = '0, last_rf = '0;
   logic [1:0]   req_now, req_prev = 2'b00;

   function automatic logic [127:0] blk(input logic [27:0] a);
      logic [127:0] b;
      if (mem.exists(a)) return mem[a];
      for (int k = 0; k < 16; k++) b[8*k +: 8] = {a[3:0], 4'(k)};
      return b;
   endfunction

   always @(negedge CLOCK) begin
      req_now = {MEM_READ, MEM_WRITE};
      if (MEM_READ && MEM_WRITE) n_excl++;
      if (req_now == 2'b00) begin
         req_cnt      = 0;
         MEM_BUSYWAIT = 1'b0;
      end else begin
         if (req_now != req_prev) req_cnt = 0;
         MEM_BUSYWAIT = (req_cnt < mem_lat);
         req_cnt++;
         if (MEM_READ) MEM_READDATA = blk(MEM_ADDRESS);
         if (!MEM_BUSYWAIT) begin
            if (MEM_WRITE) begin
               mem[MEM_ADDRESS] = MEM_WRITEDATA;
               n_wb++;
               last_wb = MEM_ADDRESS;
            end else begin
               n_rf++;
               last_rf = MEM_ADDRESS;
            end
         end
      end
      req_prev = req_now;
   end

   // Called just after a rising edge; returns load data and BUSYWAIT-high cycles.
   task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rdata, output int stall);
      READ = rd; WRITE = wr; FUNCT3 = f3; ADDRESS = a; WRITEDATA = wd;
      stall = 0;
      @(negedge CLOCK);
      while (BUSYWAIT === 1'b1 && stall < 200) begin
         stall++;
         @(negedge CLOCK);
      end
      rdata = READDATA;
      @(posedge CLOCK); #1;
      READ = 1'b0; WRITE = 1'b0;
   endtask

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      int          lat;
      logic [31:0] exp_rd;
      int          exp_stall;
   } vec_t;

   vec_t tbl[$];

   // Reference model: flat byte memory plus per-index residency.
   logic [7:0]  fm [logic [31:0]];
   bit          mv_valid [8];
   bit          mv_dirty [8];
   logic [24:0] mv_tag   [8];

   function automatic logic [7:0] fget(input logic [31:0] a);
      if (fm.exists(a)) return fm[a];
      return a[7:0];
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]  got_rd;
      logic [127:0] exp_blk;
      int           got_st;
      int           rf0;
      bit           seen;

      tbl.push_back('{1'b1, 1'b0, F3_W,  32'h0000_0040, 32'h0,         0, 32'h4342_4140, 2});
      tbl.push_back('{1'b1, 1'b0, F3_W,  32'h0000_0040, 32'h0,         0, 32'h4342_4140, 0});
      tbl.push_back('{1'b1, 1'b0, F3_B,  32'h0000_004F, 32'h0,         0, 32'h0000_004F, 0});
      tbl.push_back('{1'b0, 1'b1, F3_B,  32'h0000_004F, 32'h0000_008F, 0, 32'h0,         0});
      tbl.push_back('{1'b1, 1'b0, F3_B,  32'h0000_004F, 32'h0,         0, 32'hFFFF_FF8F, 0});
      tbl.push_back('{1'b1, 1'b0, F3_BU, 32'h0000_004F, 32'h0,         0, 32'h0000_008F, 0});
      tbl.push_back('{1'b1, 1'b0, F3_H,  32'h0000_004E, 32'h0,         0, 32'hFFFF_8F4E, 0});
      tbl.push_back('{1'b0, 1'b1, F3_B,  32'h0000_0041, 32'h0000_00AA, 0, 32'h0,         0});
      tbl.push_back('{1'b1, 1'b0, F3_W,  32'h0000_0040, 32'h0,         0, 32'h4342_AA40, 0});
      tbl.push_back('{1'b1, 1'b0, F3_W,  32'h0000_00C0, 32'h0,         3, 32'hC3C2_C1C0, 9});
      tbl.push_back('{1'b1, 1'b0, F3_HU, 32'h0000_00C2, 32'h0,         0, 32'h0000_C3C2, 0});
      tbl.push_back('{1'b1, 1'b0, F3_H,  32'h0000_00C3, 32'h0,         0, 32'hFFFF_C3C2, 0});
      tbl.push_back('{1'b1, 1'b0, F3_W,  32'h0000_00C5, 32'h0,         0, 32'hC7C6_C5C4, 0});
      tbl.push_back('{1'b1, 1'b0, F3_W,  32'h0000_0040, 32'h0,         0, 32'h4342_AA40, 2});
      tbl.push_back('{1'b0, 1'b1, F3_H,  32'h0000_0048, 32'h1234_BEEF, 0, 32'h0,         0});
      tbl.push_back('{1'b1, 1'b0, F3_W,  32'h0000_0048, 32'h0,         0, 32'h4B4A_BEEF, 0});
      tbl.push_back('{1'b0, 1'b1, F3_W,  32'h0000_004D, 32'hDEAD_BEEF, 0, 32'h0,         0});
      tbl.push_back('{1'b1, 1'b0, F3_W,  32'h0000_004C, 32'h0,         0, 32'hDEAD_BEEF, 0});
      tbl.push_back('{1'b0, 1'b1, F3_B,  32'h0000_0123, 32'h0000_0055, 5, 32'h0,         7});
      tbl.push_back('{1'b1, 1'b0, F3_W,  32'h0000_0120, 32'h0,         0, 32'h5522_2120, 0});

      // Reset with a load request held: everything must read zero.
      READ = 1'b1; ADDRESS = 32'h40;
      #1 RESET = 1'b0;
      repeat (2) @(posedge CLOCK);
      #1;
      check("rst_busywait", 32'(BUSYWAIT), 32'h0);
      check("rst_readdata", READDATA, 32'h0);
      check("rst_mem_req", {30'h0, MEM_READ, MEM_WRITE}, 32'h0);
      check("rst_mem_addr", 32'(MEM_ADDRESS), 32'h0);
      READ = 1'b0;
      RESET = 1'b1;
      @(posedge CLOCK); #1;

      foreach (tbl[i]) begin
         mem_lat = tbl[i].lat;
         access(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd, got_rd, got_st);
         check($sformatf("vec%0d_rdata", i), got_rd, tbl[i].exp_rd);
         check($sformatf("vec%0d_stall", i), 32'(got_st), 32'(tbl[i].exp_stall));
      end
      mem_lat = 0;

      for (int k = 0; k < 16; k++) exp_blk[8*k +: 8] = 8'h40 + 8'(k);
      exp_blk[15:8]    = 8'hAA;
      exp_blk[127:120] = 8'h8F;
      check_w("wb_block_4", blk(28'h4), exp_blk);
      check("wb_count", 32'(n_wb), 32'd1);
      check("wb_addr", 32'(last_wb), 32'h4);
      check("refill_count", 32'(n_rf), 32'd4);
      check("refill_last_addr", 32'(last_rf), 32'h12);

      // Simultaneous READ and WRITE on a missing address: no stall, no traffic.
      rf0 = n_rf;
      READ = 1'b1; WRITE = 1'b1; FUNCT3 = F3_W; ADDRESS = 32'h200;
      for (int c = 0; c < 3; c++) begin
         @(negedge CLOCK);
         check($sformatf("rw_busywait_c%0d", c), 32'(BUSYWAIT), 32'h0);
         check($sformatf("rw_memreq_c%0d", c), {30'h0, MEM_READ, MEM_WRITE}, 32'h0);
      end
      check("rw_readdata", READDATA, 32'h0);
      @(posedge CLOCK); #1;
      READ = 1'b0; WRITE = 1'b0;
      check("rw_no_refill", 32'(n_rf), 32'(rf0));

      // Reset in the middle of a refill.
      mem_lat = 5;
      rf0 = n_rf;
      READ = 1'b1; WRITE = 1'b0; FUNCT3 = F3_W; ADDRESS = 32'h300;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge CLOCK);
         if (MEM_READ === 1'b1) seen = 1'b1;
      end
      check("midrst_refill_started", 32'(seen), 32'h1);
      @(posedge CLOCK); #1;
      RESET = 1'b0;
      #1;
      check("midrst_busywait", 32'(BUSYWAIT), 32'h0);
      check("midrst_readdata", READDATA, 32'h0);
      check("midrst_mem_req", {30'h0, MEM_READ, MEM_WRITE}, 32'h0);
      check("midrst_mem_addr", 32'(MEM_ADDRESS), 32'h0);
      check_w("midrst_mem_wdata", MEM_WRITEDATA, 128'h0);
      @(posedge CLOCK); #1;
      READ = 1'b0;
      RESET = 1'b1;
      mem_lat = 0;
      @(posedge CLOCK); #1;
      check("midrst_no_refill_done", 32'(n_rf), 32'(rf0));
      access(1'b1, 1'b0, F3_W, 32'h300, 32'h0, got_rd, got_st);
      check("postrst_rdata_300", got_rd, 32'h0302_0100);
      check("postrst_stall_300", 32'(got_st), 32'd2);
      access(1'b1, 1'b0, F3_W, 32'h4C, 32'h0, got_rd, got_st);
      check("postrst_rdata_4c", got_rd, 32'h8F4E_4D4C);
      check("postrst_stall_4c", 32'(got_st), 32'd2);
      check("postrst_no_wb", 32'(n_wb), 32'd1);

      // Random traffic in a fresh region, cache emptied first.
      RESET = 1'b0;
      @(posedge CLOCK); #1;
      RESET = 1'b1;
      @(posedge CLOCK); #1;
      for (int i = 0; i < 300; i++) begin
         logic        rd, wr;
         logic [2:0]  f3, idx;
         logic [24:0] tg;
         logic [31:0] a, aa, wd, exp_rd;
         int          l, nb, exp_st, sel;
         sel = int'($urandom_range(0, 9));
         rd = (sel == 0) || (sel > 4);
         wr = (sel <= 4);
         a  = 32'h1000_0000 | $urandom_range(0, 1023);
         wd = $urandom;
         l  = int'($urandom_range(0, 3));
         if (wr && !rd) begin
            f3 = 3'($urandom_range(0, 2));
         end else begin
            sel = int'($urandom_range(0, 4));
            f3  = (sel < 3) ? 3'(sel) : 3'(sel + 1);
         end
         nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
         aa = a & ~32'(nb - 1);
         exp_rd = 32'h0;
         exp_st = 0;
         if (rd ^ wr) begin
            idx = a[6:4];
            tg  = a[31:7];
            if (!(mv_valid[idx] && mv_tag[idx] == tg)) begin
               exp_st = (mv_valid[idx] && mv_dirty[idx]) ? 1 + 2 * (l + 1) : 1 + (l + 1);
               mv_valid[idx] = 1'b1;
               mv_dirty[idx] = 1'b0;
               mv_tag[idx]   = tg;
            end
            if (wr) begin
               mv_dirty[idx] = 1'b1;
               for (int k = 0; k < nb; k++) fm[aa + 32'(k)] = wd[8*k +: 8];
            end else begin
               for (int k = 0; k < nb; k++) exp_rd[8*k +: 8] = fget(aa + 32'(k));
               if (!f3[2] && nb < 4 && exp_rd[8*nb-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8 * nb));
            end
         end
         mem_lat = l;
         access(rd, wr, f3, a, wd, got_rd, got_st);
         check($sformatf("rnd%0d_rdata a=%0h f3=%0d", i, a, f3), got_rd, exp_rd);
         check($sformatf("rnd%0d_stall a=%0h", i, a), 32'(got_st), 32'(exp_st));
      end

      check("mem_req_exclusive", 32'(n_excl), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
